// File: rtl/mem_arbiter_if.sv
// Signal bundle between the CPU/DMA requesters, the arbiter and the data memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req0, req1, we0, we1;
    logic [31:0]       addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [5:0]        op0, op1;
    logic              gnt0, gnt1, ack0, ack1, err0, err1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_en, mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, op0, op1, mem_rdata,
        output gnt0, gnt1, ack0, ack1, err0, err1, rdata0, rdata1,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, op0, op1, mem_rdata,
        input  gnt0, gnt1, ack0, ack1, err0, err1, rdata0, rdata1,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU=0, DMA=1) arbiter in front of a synchronous-read data memory.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 win every tie instead of round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam logic [5:0] OP_SB = 6'h28;
    localparam logic [5:0] OP_SH = 6'h29;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             gnt_q, gnt_d, ack_q, ack_d, err_q, err_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
    logic                   mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [3:0]             mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic                   busy_q, busy_d;
    logic                   port_q, port_d, we_q, we_d, oor_q, oor_d;

    logic                   win, sel_we, sel_oor;
    logic [31:0]            sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic [5:0]             sel_op;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign win = ~bus.req0;
`else
    // last_q remembers the most recent grant; a tie goes to the other port.
    logic last_q, last_d;
    assign win    = (bus.req0 && bus.req1) ? ~last_q : ~bus.req0;
    assign last_d = (state_q == IDLE && (bus.req0 || bus.req1)) ? win : last_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end
`endif

    assign sel_we    = win ? bus.we1    : bus.we0;
    assign sel_addr  = win ? bus.addr1  : bus.addr0;
    assign sel_wdata = win ? bus.wdata1 : bus.wdata0;
    assign sel_op    = win ? bus.op1    : bus.op0;
    assign sel_oor   = |sel_addr[31:ADDR_W];

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        ack_d       = '0;
        err_d       = '0;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        port_d      = port_q;
        we_d        = we_q;
        oor_d       = oor_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d      = ISSUE;
                    gnt_d[win]   = 1'b1;
                    port_d       = win;
                    we_d         = sel_we;
                    oor_d        = sel_oor;
                    // Memory strobe is prepared here so it is registered for the ISSUE cycle.
                    mem_en_d     = ~sel_oor;
                    mem_we_d     = sel_we & ~sel_oor;
                    mem_addr_d   = sel_addr[ADDR_W-1:0];
                    if (sel_we) begin
                        case (sel_op)
                            OP_SB: begin
                                mem_be_d    = 4'b0001;
                                mem_wdata_d = DATA_W'(sel_wdata[7:0]);
                            end
                            OP_SH: begin
                                mem_be_d    = 4'b0011;
                                mem_wdata_d = DATA_W'(sel_wdata[15:0]);
                            end
                            default: begin
                                mem_be_d    = 4'b1111;
                                mem_wdata_d = sel_wdata;
                            end
                        endcase
                    end
                end
            end
            ISSUE: begin
                if (we_q || oor_q) begin
                    state_d        = RESP;
                    ack_d[port_q]  = 1'b1;
                    err_d[port_q]  = oor_q;
                    if (oor_q) rdata_d[port_q] = '0;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d         = RESP;
                ack_d[port_q]   = 1'b1;
                rdata_d[port_q] = bus.mem_rdata;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            ack_q       <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            port_q      <= port_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
        end
    end

    assign bus.gnt0      = gnt_q[0];
    assign bus.gnt1      = gnt_q[1];
    assign bus.ack0      = ack_q[0];
    assign bus.ack1      = ack_q[1];
    assign bus.err0      = err_q[0];
    assign bus.err1      = err_q[1];
    assign bus.rdata0    = rdata_q[0];
    assign bus.rdata1    = rdata_q[1];
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level reference model plus directed corner cases.
module tb_mem_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam logic [5:0] SB = 6'h28;
    localparam logic [5:0] SH = 6'h29;
    localparam logic [5:0] SW = 6'h2b;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory environment: synchronous read, byte-lane writes, preload port.
    logic [31:0] ram [256];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (bus.mem_en) begin
            if (bus.mem_we)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    // Reference model state
    logic [31:0] refm [256];
    logic [1:0]  p_act, p_we;
    logic [31:0] p_addr [2];
    logic [31:0] p_wd   [2];
    logic [5:0]  p_op   [2];
    int          c, free_from, ack_cyc, gen_pct;
    int          n_gnt [2];
    bit          m_last, ack_port, ack_err, ack_chk;
    logic [31:0] ack_data;

    function automatic logic [3:0] be_of(input logic we, input logic [5:0] op);
        if (!we)       return 4'b0000;
        if (op == SB)  return 4'b0001;
        if (op == SH)  return 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] be);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hff;
        return m;
    endfunction

    task automatic drive();
        bus.req0 = p_act[0]; bus.we0 = p_we[0]; bus.addr0 = p_addr[0]; bus.wdata0 = p_wd[0]; bus.op0 = p_op[0];
        bus.req1 = p_act[1]; bus.we1 = p_we[1]; bus.addr1 = p_addr[1]; bus.wdata1 = p_wd[1]; bus.op1 = p_op[1];
    endtask

    task automatic set_txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [5:0] op);
        p_act[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wd[p] = d; p_op[p] = op;
    endtask

    task automatic rand_txn(input int p);
        logic [31:0] a;
        logic [5:0]  op;
        if ($urandom_range(0, 11) == 0) a = (32'h100 << $urandom_range(0, 23)) | 32'($urandom_range(0, 255));
        else                            a = 32'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
            0:       op = SB;
            1:       op = SH;
            2:       op = SW;
            default: op = 6'($urandom);
        endcase
        set_txn(p, 1'($urandom_range(0, 1)), a, $urandom, op);
    endtask

    // One clock of checking against the transaction-level model, then next-cycle stimulus.
    task automatic step();
        logic [1:0]  rq, eg, ea;
        logic [31:0] a, mask;
        logic [3:0]  be;
        bit          w, oor;
        @(negedge clk);
        c++;
        rq = {bus.req1, bus.req0};
        eg = 2'b00;
        w  = 1'b0;
        if ((c - 1) >= free_from && rq != 2'b00) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            w = !rq[0];
`else
            w = (rq == 2'b11) ? !m_last : !rq[0];
`endif
            eg[w] = 1'b1;
        end
        chk("gnt", {bus.gnt1, bus.gnt0}, eg);
        if (eg != 2'b00) begin
            a   = p_addr[w];
            oor = (a[31:8] != 0);
            be  = be_of(p_we[w], p_op[w]);
            chk("mem_en", bus.mem_en, !oor);
            ack_data = 32'h0;
            if (!oor) begin
                chk("mem_we", bus.mem_we, p_we[w]);
                chk("mem_be", bus.mem_be, be);
                chk("mem_addr", bus.mem_addr, a[7:0]);
                if (p_we[w]) begin
                    mask = lanes(be);
                    chk("mem_wdata", bus.mem_wdata & mask, p_wd[w] & mask);
                    refm[a[7:0]] = (refm[a[7:0]] & ~mask) | (p_wd[w] & mask);
                end else begin
                    ack_data = refm[a[7:0]];
                end
            end
            ack_port  = w;
            ack_err   = oor;
            ack_chk   = oor || !p_we[w];
            ack_cyc   = c + ((!oor && !p_we[w]) ? 2 : 1);
            free_from = ack_cyc + 1;
            m_last    = w;
            n_gnt[w]++;
            p_act[w]  = 1'b0;
        end else begin
            chk("mem_en_idle", bus.mem_en, 1'b0);
        end
        ea = (c == ack_cyc) ? (ack_port ? 2'b10 : 2'b01) : 2'b00;
        chk("ack", {bus.ack1, bus.ack0}, ea);
        if (ea != 2'b00) begin
            chk("err", ack_port ? bus.err1 : bus.err0, ack_err);
            if (ack_chk) chk("rdata", ack_port ? bus.rdata1 : bus.rdata0, ack_data);
        end
        chk("busy", bus.busy, c < free_from);
        for (int p = 0; p < 2; p++)
            if (!p_act[p] && $urandom_range(0, 99) < gen_pct) rand_txn(p);
        drive();
    endtask

    task automatic settle(input int budget);
        int n = 0;
        while ((p_act != 2'b00 || c < free_from) && n < budget) begin
            step();
            n++;
        end
        chk("settle_timeout", (p_act != 2'b00 || c < free_from), 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},   {bus.gnt1, bus.gnt0}, 2'b00);
        chk({tag, "_ack"},   {bus.ack1, bus.ack0}, 2'b00);
        chk({tag, "_err"},   {bus.err1, bus.err0}, 2'b00);
        chk({tag, "_rdata"}, {bus.rdata1, bus.rdata0}, 64'h0);
        chk({tag, "_mem"},   {bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr}, 14'h0);
        chk({tag, "_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, "_busy"},  bus.busy, 1'b0);
    endtask

    task automatic model_reset();
        free_from = 0; ack_cyc = -1; m_last = 1'b1;
    endtask

    initial begin
        int diff;
        p_act = '0; p_we = '0; gen_pct = 0; c = 0;
        for (int p = 0; p < 2; p++) begin p_addr[p] = '0; p_wd[p] = '0; p_op[p] = '0; n_gnt[p] = 0; end
        model_reset();
        drive();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1 chk_zero("reset");

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pl_we = 1'b1; pl_addr = 8'(i); pl_data = $urandom; refm[i] = pl_data;
        end
        @(negedge clk);
        pl_addr = 8'd7; pl_data = 32'h11223344; refm[7] = pl_data;
        @(negedge clk);
        pl_we = 1'b0;
        reset = 1'b0;

        // Port 0 word store
        set_txn(0, 1'b1, 32'd5, 32'hDEADBEEF, SW); drive();
        step();
        chk("t033_gnt0", bus.gnt0, 1'b1);
        chk("t033_be", bus.mem_be, 4'b1111);
        chk("t033_addr", bus.mem_addr, 8'd5);
        step();
        chk("t033_ack0", bus.ack0, 1'b1);
        chk("t033_err0", bus.err0, 1'b0);
        settle(10);

        // Port 1 byte store then word load of the same address
        set_txn(1, 1'b1, 32'd7, 32'h000000AB, SB); drive();
        step();
        chk("t034_be", bus.mem_be, 4'b0001);
        settle(10);
        set_txn(1, 1'b0, 32'd7, 32'h0, 6'h23); drive();
        step(); step();
        chk("t034_noack_t2", bus.ack1, 1'b0);
        step();
        chk("t034_ack1", bus.ack1, 1'b1);
        chk("t034_rdata1", bus.rdata1, 32'h112233AB);
        settle(10);

        // Out-of-range load
        set_txn(0, 1'b0, 32'h00000100, 32'h0, 6'h23); drive();
        step();
        chk("t036_en", bus.mem_en, 1'b0);
        step();
        chk("t036_ack0", bus.ack0, 1'b1);
        chk("t036_err0", bus.err0, 1'b1);
        chk("t036_rdata0", bus.rdata0, 32'h0);
        settle(10);

        // Both ports requesting continuously
        n_gnt[0] = 0; n_gnt[1] = 0; gen_pct = 100;
        repeat (60) step();
        gen_pct = 0;
        settle(20);
`ifdef MEM_ARB_FIXED_PRIO_EN
        chk("t035_prio", n_gnt[1], 0);
`else
        diff = n_gnt[0] - n_gnt[1];
        chk("t035_rr", (diff >= -1 && diff <= 1 && n_gnt[0] > 5), 1'b1);
`endif

        // Reset while a load is in WAIT
        set_txn(0, 1'b0, 32'd3, 32'h0, 6'h23); drive();
        step();
        chk("t037_gnt0", bus.gnt0, 1'b1);
        step();
        reset = 1'b1;
        #1 chk_zero("t037_rst");
        repeat (3) begin
            @(negedge clk);
            chk("t037_noack", {bus.ack1, bus.ack0}, 2'b00);
        end
        reset = 1'b0;
        model_reset();
        rand_txn(0); rand_txn(1); drive();
        step();
        chk("t037_tie", {bus.gnt1, bus.gnt0}, 2'b01);
        settle(10);

        // Random traffic
        gen_pct = 40;
        repeat (3000) step();
        gen_pct = 0;
        settle(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the data memory (256 words).
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports reqN  input  1  access request, held until gntN (N = 0 CPU, 1 DMA).
REQ-006 SHALL have ports weN  input  1  1 = store, 0 = load.
REQ-007 SHALL have ports addrN  input  32  word address.
REQ-008 SHALL have ports wdataN  input  DATA_W  store data.
REQ-009 SHALL have ports opN  input  6  MIPS opcode; 6'h28 = sb, 6'h29 = sh, any other = word.
REQ-010 SHALL have ports gntN  output  1  one-cycle pulse: request accepted.
REQ-011 SHALL have ports ackN  output  1  one-cycle pulse: access complete.
REQ-012 SHALL have ports errN  output  1  valid with ackN: address out of range.
REQ-013 SHALL have ports rdataN  output  DATA_W  load data, valid with ackN.
REQ-014 SHALL have ports mem_en, mem_we  output  1  memory strobe and write enable.
REQ-015 SHALL have ports mem_be  output  4  byte-lane write enables.
REQ-016 SHALL have ports mem_addr  output  ADDR_W;  mem_wdata  output  DATA_W;  mem_rdata  input  DATA_W  (synchronous read, data valid one cycle after mem_en).
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-019 IDLE: if any reqN is high, latch winner's we/addr/wdata/op, pulse gntN next cycle, go ISSUE; else stay.
REQ-020 ISSUE (1 cycle): drive mem_en=1, mem_we=we, mem_addr=addr[ADDR_W-1:0], mem_be/mem_wdata per REQ-023; store -> RESP, load -> WAIT.
REQ-021 WAIT (1 cycle): capture mem_rdata into rdataN; -> RESP.
REQ-022 RESP (1 cycle): pulse ackN; -> IDLE; reqN is not sampled in RESP (one bubble between accesses).
REQ-023 Lanes: sb -> be=4'b0001, wdata[7:0] on lane 0; sh -> be=4'b0011, wdata[15:0] on lanes 0-1; other -> be=4'b1111; loads always return full word, be=0.
REQ-024 Latency: req seen in IDLE cycle T -> gnt and mem_en in T+1; store ack in T+2; load ack with rdata in T+3.
REQ-025 If addr[31:ADDR_W] != 0: mem_en stays 0 in ISSUE, skip WAIT, RESP pulses ackN with errN=1, rdataN=0.
REQ-026 Simultaneous req0 and req1 in IDLE: round-robin; grant the port not granted last; last-grant pointer resets to 1 (port 0 wins first tie).
REQ-027 Single requester SHALL be granted regardless of pointer; pointer updates on every grant.
REQ-028 gnt0 and gnt1 SHALL never be high in the same cycle; likewise ack0/ack1.
REQ-029 reqN dropped after gnt SHALL NOT cancel the access.

Reset
REQ-030 Reset SHALL asynchronously force IDLE, pointer=1, and all outputs (gnt, ack, err, rdata, mem_*, busy) to 0.
REQ-031 Reset mid-access SHALL abort it: no ack issued, any pending memory write not retried.

Configuration
REQ-032 With MEM_ARB_FIXED_PRIO_EN defined, ties SHALL always grant port 0 and the pointer is unused; without it, REQ-026 round-robin applies.

Verification
REQ-033 Port 0 sw addr 5, data 32'hDEADBEEF -> gnt0 at T+1, mem_be=1111, mem_addr=5, ack0 at T+2, err0=0.
REQ-034 Port 1 sb addr 7 data 32'h000000AB, then lw addr 7 (mem model pre-loaded 32'h11223344) -> mem_be=0001, then ack1 at T+3 with rdata1=32'h112233AB.
REQ-035 req0 and req1 held high continuously -> grants alternate 0,1,0,1 (fixed-prio build: always 0 until req0 drops).
REQ-036 Port 0 lw addr 32'h00000100 -> mem_en never asserted, ack0 with err0=1, rdata0=0.
REQ-037 reset asserted in WAIT of a load -> all outputs 0 immediately, no ack; next request served normally with port 0 winning a tie.
